// File: rtl/aes_key_sched_ctrl.sv
// Sequences the AES-128 key expander and stores round keys 0..10 for random-order reads.
// Latency: key handshake to keys_ready is 12 cycles; round-key reads return 1 cycle after request.
// Backpressure: key_ready is low during LOAD/EXPAND, so upstream holds key_valid/key_in until accepted.
module aes_key_sched_ctrl #(
   parameter int NR = 10
) (
   input  logic         CLK,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key_in,
   output logic         exp_valid,
   output logic         exp_en,
   output logic [127:0] exp_key,
   input  logic [127:0] exp_rnd0,
   input  logic [127:0] exp_rndn,
   output logic         keys_ready,
   output logic         busy,
   input  logic         rk_rd_en,
   input  logic [3:0]   rk_addr,
   output logic [127:0] rk_data,
   output logic         rk_rd_valid
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      EXPAND = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LAST_RND = 4'(NR);

   state_t       state;
   state_t       state_nxt;
   logic [127:0] key_reg;
   logic [3:0]   rnd_cnt;
   logic [127:0] store [0:NR];
   logic         key_hs;

   assign key_hs  = key_valid && key_ready;
   assign exp_key = key_reg;

   // State register.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and strobe decode; exp_en stops once the last round is on exp_rndn.
   always_comb begin
      state_nxt  = state;
      key_ready  = 1'b0;
      keys_ready = 1'b0;
      busy       = 1'b0;
      exp_valid  = 1'b0;
      exp_en     = 1'b0;
      case (state)
         IDLE: begin
            key_ready = 1'b1;
            if (key_valid) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            busy      = 1'b1;
            exp_valid = 1'b1;
            state_nxt = EXPAND;
         end
         EXPAND: begin
            busy = 1'b1;
            if (rnd_cnt < LAST_RND) begin
               exp_en = 1'b1;
            end else begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            key_ready  = 1'b1;
            keys_ready = 1'b1;
            if (key_valid) begin
               state_nxt = LOAD;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Key latch and round counter; the counter saturates at the last round.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         key_reg <= '0;
         rnd_cnt <= '0;
      end else begin
         if (key_hs) begin
            key_reg <= key_in;
         end
         if (state == LOAD) begin
            rnd_cnt <= 4'd1;
         end else if ((state == EXPAND) && (rnd_cnt < LAST_RND)) begin
            rnd_cnt <= rnd_cnt + 4'd1;
         end
      end
   end

   // Round-key capture; contents are left alone by reset since reads are gated by keys_ready.
   always_ff @(posedge CLK) begin
      if (rst_n && (state == LOAD)) begin
         store[0] <= exp_rnd0;
      end
      if (rst_n && (state == EXPAND)) begin
         store[rnd_cnt] <= exp_rndn;
      end
   end

   // Registered read port; out-of-range indices return zero, reads before completion are dropped.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         rk_rd_valid <= 1'b0;
         rk_data     <= '0;
      end else if (rk_rd_en && keys_ready) begin
         rk_rd_valid <= 1'b1;
         if (rk_addr <= LAST_RND) begin
            rk_data <= store[rk_addr];
         end else begin
            rk_data <= '0;
         end
      end else begin
         rk_rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;

   localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K3     = 128'hfedcba98765432100123456789abcdef;

   logic         CLK;
   logic         rst_n;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;
   logic         exp_valid;
   logic         exp_en;
   logic [127:0] exp_key;
   logic [127:0] exp_rnd0;
   logic [127:0] exp_rndn;
   logic         keys_ready;
   logic         busy;
   logic         rk_rd_en;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;
   logic         rk_rd_valid;

   int checks = 0;
   int errors = 0;
   logic [127:0] ref_rk [0:10];

   aes_key_sched_ctrl #(.NR(10)) dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_in     (key_in),
      .exp_valid  (exp_valid),
      .exp_en     (exp_en),
      .exp_key    (exp_key),
      .exp_rnd0   (exp_rnd0),
      .exp_rndn   (exp_rndn),
      .keys_ready (keys_ready),
      .busy       (busy),
      .rk_rd_en   (rk_rd_en),
      .rk_addr    (rk_addr),
      .rk_data    (rk_data),
      .rk_rd_valid(rk_rd_valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // GF(2^8) arithmetic for the reference AES-128 key expansion.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input int r);
      case (r)
         1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
         5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
         9: return 8'h1b; 10: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] next_rk(input logic [127:0] k, input int r);
      logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(r), 24'h0};
      n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   task automatic compute_ref(input logic [127:0] k);
      ref_rk[0] = k;
      for (int r = 1; r <= 10; r++) ref_rk[r] = next_rk(ref_rk[r-1], r);
   endtask

   // Behavioural key expander: round 0 follows Key_in, Valid loads round 1, En_Exp steps.
   logic [127:0] mdl_rndn;
   int           mdl_cnt;
   assign exp_rnd0 = exp_key;
   assign exp_rndn = mdl_rndn;
   always @(posedge CLK) begin
      if (exp_valid) begin
         mdl_rndn <= next_rk(exp_key, 1);
         mdl_cnt  <= 1;
      end else if (exp_en) begin
         mdl_rndn <= next_rk(mdl_rndn, mdl_cnt + 1);
         mdl_cnt  <= mdl_cnt + 1;
      end
   end

   task automatic test_reset;
      rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_rd_en = 1'b0; rk_addr = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({key_ready, keys_ready, busy, exp_valid, exp_en, rk_rd_valid} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 100000 (key_ready,keys_ready,busy,exp_valid,exp_en,rk_rd_valid)",
                  {key_ready, keys_ready, busy, exp_valid, exp_en, rk_rd_valid});
      end
      checks++;
      if (rk_data !== 128'h0) begin
         errors++; $display("FAIL reset_rk_data: got %h want 0", rk_data);
      end
      checks++;
      if (exp_key !== 128'h0) begin
         errors++; $display("FAIL reset_exp_key: got %h want 0", exp_key);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_expand_strobes;
      int nv;
      int ne;
      nv = 0; ne = 0;
      key_in = K1; key_valid = 1'b1;
      @(posedge CLK);
      for (int c = 1; c <= 12; c++) begin
         @(negedge CLK);
         if (c == 1) key_valid = 1'b0;
         if (exp_valid) nv++;
         if (exp_en) ne++;
         checks++;
         if (exp_en !== 1'((c >= 2) && (c <= 10))) begin
            errors++; $display("FAIL strobe_exp_en cycle A+%0d: got %b want %b", c, exp_en, (c >= 2) && (c <= 10));
         end
         checks++;
         if (exp_valid !== 1'(c == 1)) begin
            errors++; $display("FAIL strobe_exp_valid cycle A+%0d: got %b want %b", c, exp_valid, c == 1);
         end
         checks++;
         if (exp_key !== K1) begin
            errors++; $display("FAIL strobe_exp_key cycle A+%0d: got %h want %h", c, exp_key, K1);
         end
         checks++;
         if ({keys_ready, busy} !== {1'(c == 12), 1'(c <= 11)}) begin
            errors++; $display("FAIL strobe_keys_ready_busy cycle A+%0d: got %b%b want %b%b",
                               c, keys_ready, busy, c == 12, c <= 11);
         end
      end
      checks++;
      if (nv != 1 || ne != 9) begin
         errors++; $display("FAIL strobe_counts: got valid=%0d en=%0d want valid=1 en=9", nv, ne);
      end
   endtask

   task automatic test_read_basic;
      logic [127:0] want [0:2];
      logic [3:0]   addrs [0:2];
      want[0] = K1;  want[1] = K1_R1; want[2] = K1_R10;
      addrs[0] = 4'd0; addrs[1] = 4'd1; addrs[2] = 4'd10;
      for (int i = 0; i <= 3; i++) begin
         if (i > 0) begin
            checks++;
            if (rk_rd_valid !== 1'b1 || rk_data !== want[i-1]) begin
               errors++; $display("FAIL read_basic addr %0d: got v=%b %h want v=1 %h",
                                  addrs[i-1], rk_rd_valid, rk_data, want[i-1]);
            end
         end
         if (i < 3) begin
            rk_rd_en = 1'b1; rk_addr = addrs[i];
         end else begin
            rk_rd_en = 1'b0;
         end
         @(negedge CLK);
      end
      checks++;
      if (rk_rd_valid !== 1'b0 || rk_data !== K1_R10) begin
         errors++; $display("FAIL read_idle_hold: got v=%b %h want v=0 %h", rk_rd_valid, rk_data, K1_R10);
      end
   endtask

   task automatic test_reverse;
      logic [127:0] want;
      compute_ref(K1);
      for (int i = 0; i <= 12; i++) begin
         if (i > 0) begin
            want = (i <= 11) ? ref_rk[11-i] : 128'h0;
            checks++;
            if (rk_rd_valid !== 1'b1 || rk_data !== want) begin
               errors++; $display("FAIL reverse_read step %0d: got v=%b %h want v=1 %h", i, rk_rd_valid, rk_data, want);
            end
         end
         if (i < 11) begin
            rk_rd_en = 1'b1; rk_addr = 4'(10 - i);
         end else if (i == 11) begin
            rk_addr = 4'd12;
         end else begin
            rk_rd_en = 1'b0;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_back_to_back;
      logic [127:0] k2_r10;
      compute_ref(K2);
      k2_r10 = ref_rk[10];
      key_in = K2; key_valid = 1'b1;
      @(posedge CLK);
      for (int c = 1; c <= 24; c++) begin
         @(negedge CLK);
         if (c == 1) key_in = K3;
         if (c <= 11) begin
            checks++;
            if (key_ready !== 1'b0 || exp_key !== K2) begin
               errors++; $display("FAIL busy_hold cycle A+%0d: got key_ready=%b key=%h want 0 %h", c, key_ready, exp_key, K2);
            end
         end
         if (c == 12) begin
            checks++;
            if (key_ready !== 1'b1 || keys_ready !== 1'b1) begin
               errors++; $display("FAIL busy_release: got key_ready=%b keys_ready=%b want 1 1", key_ready, keys_ready);
            end
            rk_rd_en = 1'b1; rk_addr = 4'd10;
         end
         if (c == 13) begin
            checks++;
            if (keys_ready !== 1'b0 || exp_valid !== 1'b1 || exp_key !== K3) begin
               errors++; $display("FAIL second_accept: got keys_ready=%b exp_valid=%b key=%h want 0 1 %h",
                                  keys_ready, exp_valid, exp_key, K3);
            end
            checks++;
            if (rk_rd_valid !== 1'b1 || rk_data !== k2_r10) begin
               errors++; $display("FAIL read_at_accept: got v=%b %h want v=1 %h", rk_rd_valid, rk_data, k2_r10);
            end
            key_valid = 1'b0; rk_addr = 4'd0;
         end
         if (c == 14) begin
            checks++;
            if (rk_rd_valid !== 1'b0 || rk_data !== k2_r10) begin
               errors++; $display("FAIL read_during_load: got v=%b %h want v=0 %h", rk_rd_valid, rk_data, k2_r10);
            end
            rk_rd_en = 1'b0;
         end
         if (c == 23 || c == 24) begin
            checks++;
            if (keys_ready !== 1'(c == 24)) begin
               errors++; $display("FAIL second_keys_ready cycle A+%0d: got %b want %b", c, keys_ready, c == 24);
            end
         end
      end
      compute_ref(K3);
      rk_rd_en = 1'b1; rk_addr = 4'd10;
      @(negedge CLK);
      rk_rd_en = 1'b0;
      checks++;
      if (rk_rd_valid !== 1'b1 || rk_data !== ref_rk[10]) begin
         errors++; $display("FAIL second_key_r10: got v=%b %h want v=1 %h", rk_rd_valid, rk_data, ref_rk[10]);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      key_in = K1; key_valid = 1'b1;
      @(posedge CLK);
      for (int c = 1; c <= 11; c++) begin
         @(negedge CLK);
         if (c == 1) key_valid = 1'b0;
         if (c == 6) rst_n = 1'b0;
         if (c == 7) begin
            checks++;
            if ({key_ready, keys_ready, busy, exp_en, exp_valid} !== 5'b10000 || exp_key !== 128'h0) begin
               errors++; $display("FAIL reset_mid_state: got %b key=%h want 10000 key=0",
                                  {key_ready, keys_ready, busy, exp_en, exp_valid}, exp_key);
            end
            rst_n = 1'b1; rk_rd_en = 1'b1; rk_addr = 4'd0;
         end
         if (c == 8) begin
            checks++;
            if (rk_rd_valid !== 1'b0) begin
               errors++; $display("FAIL reset_mid_read: got v=%b want 0", rk_rd_valid);
            end
            rk_rd_en = 1'b0;
         end
         if (c > 8) begin
            checks++;
            if (exp_en !== 1'b0 || exp_valid !== 1'b0 || keys_ready !== 1'b0) begin
               errors++; $display("FAIL reset_mid_quiet cycle A+%0d: got en=%b valid=%b keys_ready=%b want 0 0 0",
                                  c, exp_en, exp_valid, keys_ready);
            end
         end
      end
      key_in = K1; key_valid = 1'b1;
      @(posedge CLK);
      n = 0;
      while (n < 40) begin
         @(negedge CLK);
         n++;
         if (n == 1) key_valid = 1'b0;
         if (keys_ready === 1'b1) break;
      end
      checks++;
      if (n != 12) begin
         errors++; $display("FAIL reset_mid_reexpand: keys_ready after %0d cycles want 12", n);
      end
      rk_rd_en = 1'b1; rk_addr = 4'd10;
      @(negedge CLK);
      rk_rd_en = 1'b0;
      checks++;
      if (rk_rd_valid !== 1'b1 || rk_data !== K1_R10) begin
         errors++; $display("FAIL reset_mid_r10: got v=%b %h want v=1 %h", rk_rd_valid, rk_data, K1_R10);
      end
   endtask

   initial begin
      test_reset();
      test_expand_strobes();
      test_read_basic();
      test_reverse();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencing and storage stage placed directly downstream of the AES-128 key expander. Accepts a cipher key over a valid/ready handshake, drives the expander's load and step strobes, captures all 11 round keys (0..10) into an internal key store, then serves them by round index to the cipher round datapath with one-cycle registered reads. It lets the round datapath read keys in any order, including reverse order for decryption, without re-running expansion.

## Interface
- NR, 10, number of expansion rounds; only 10 (AES-128) is legal
- CLK  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- key_valid  in  1  new cipher key offered
- key_ready  out  1  block can accept a key (state IDLE or DONE)
- key_in  in  128  cipher key, byte 0 in [127:120]
- exp_valid  out  1  load strobe to the expander's Valid
- exp_en  out  1  step strobe to the expander's En_Exp
- exp_key  out  128  key to the expander's Key_in, held stable for the whole expansion
- exp_rnd0  in  128  expander round-0 key
- exp_rndn  in  128  expander current round-n key
- keys_ready  out  1  all 11 round keys valid in the store
- busy  out  1  expansion in progress (LOAD or EXPAND)
- rk_rd_en  in  1  round-key read request
- rk_addr  in  4  round index 0..10
- rk_data  out  128  registered round key
- rk_rd_valid  out  1  rk_data valid this cycle

## Operation
- FSM states: IDLE, LOAD, EXPAND, DONE.
- IDLE: key_ready=1, keys_ready=0. On key_valid&&key_ready, latch key_in into key_reg and go to LOAD.
- LOAD (1 cycle): exp_valid=1. Write exp_rnd0 into store[0]. Set rnd_cnt=1. Go to EXPAND.
- EXPAND: each cycle, write exp_rndn into store[rnd_cnt].
  - rnd_cnt<10: exp_en=1, rnd_cnt++.
  - rnd_cnt==10: exp_en=0, go to DONE.
- DONE: keys_ready=1, key_ready=1. Accepting a new key leaves DONE for LOAD and drops keys_ready the next cycle.
- Per key, exactly 1 exp_valid pulse and 9 exp_en pulses; exp_valid and exp_en are never high together.
- exp_key = key_reg at all times; key_reg changes only on handshake.
- rnd_cnt is 4 bits and never exceeds 10.
- Reads:
  - Sampled when rk_rd_en=1 and keys_ready=1.
  - rk_addr 0..10: rk_data=store[rk_addr] and rk_rd_valid=1 on the next cycle.
  - rk_addr 11..15: rk_data=0 and rk_rd_valid=1.
  - Read requests while keys_ready=0 are ignored: rk_rd_valid=0 next cycle and rk_data holds its value.
- key_valid while busy: not accepted (key_ready=0); the upstream must hold the key.

## Timing
- Handshake at edge A. LOAD occupies cycle A+1. EXPAND occupies A+2..A+11, capturing rounds 1..10. exp_en is high A+2..A+10. DONE and keys_ready=1 from A+12.
- Handshake to keys_ready: 12 cycles. Back-to-back keys: one accepted per 12 cycles.
- Read latency is 1 cycle, fully pipelined (one read per cycle).
- Read issued in the same DONE cycle a new key is accepted: it is served with the old key's data.
- Reset values (after a rising edge with rst_n=0):
  - state IDLE, key_ready=1, keys_ready=0, busy=0.
  - exp_valid=0, exp_en=0, rk_rd_valid=0, rk_data=0, key_reg=0, rnd_cnt=0.
  - The store is not cleared; reads are gated by keys_ready.
- Reset mid-expansion: state returns to IDLE at that edge, no further strobes are issued, and keys_ready stays 0 until a complete new expansion finishes.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c with a real expander attached, then read addresses 0,1,10:
  - keys_ready at A+12.
  - rk_data = 2b7e1516..., then a0fafe1788542cb123a339392a6c7605, then d014f9a8c9ee2589e13f0cc8b6630ca6, each one cycle after its request.
- Strobe check: count exp_valid pulses = 1 and exp_en pulses = 9, with exp_en high exactly A+2..A+10 and exp_key stable throughout.
- key_valid held high during busy with a second key:
  - key_ready=0 until A+12.
  - The second key is accepted at the A+12 edge and keys_ready falls at A+13.
- Reverse reads 10..0 on consecutive cycles: rk_rd_valid high for 11 consecutive cycles, data in reverse order. rk_addr=12 returns 0 with rk_rd_valid=1.
- rst_n=0 at A+6:
  - Next cycle: IDLE, exp_en=0, keys_ready=0.
  - A read request then gives rk_rd_valid=0.
  - A fresh expansion then completes in 12 cycles.
- Read issued while keys_ready=0 (during LOAD): rk_rd_valid=0 and rk_data unchanged.
